// File: rtl/chargen_pkg.sv
// Shared types and constants for the character RAM arbiter.
package chargen_pkg;

  localparam int unsigned CHAR_BANK_AW = 13;
  localparam int unsigned CHAR_RAM_AW  = CHAR_BANK_AW + 1;
  localparam int unsigned CHAR_DW      = 8;
  localparam int unsigned ROM_ID_W     = 6;
  localparam int unsigned ID_BL_DEF    = 12;
  localparam int unsigned ID_BH_DEF    = 13;

  // One buffered download byte bound for the character RAM.
  typedef struct packed {
    logic                    bank;
    logic [CHAR_BANK_AW-1:0] addr;
    logic [CHAR_DW-1:0]      data;
  } chargen_wr_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_WRITE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/chargen_wr_fifo.sv
// Small synchronous FIFO buffering download writes until the RAM is idle.
module chargen_wr_fifo
  import chargen_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             push_i,
  input  chargen_wr_t      wdata_i,
  input  logic             pop_i,
  output chargen_wr_t      rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  chargen_wr_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy tracking; push and pop together leave count unchanged.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/chargen_arbiter.sv
// Shares the single-port character RAM between video dot fetches (priority,
// fixed 3-cycle latency) and buffered ROM download writes.
module chargen_arbiter
  import chargen_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ID_BL      = ID_BL_DEF,
  parameter int unsigned ID_BH      = ID_BH_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        profile,
  input  logic        vid_req,
  input  logic [12:0] dotA,
  output logic [7:0]  dotD,
  output logic        dot_valid,
  input  logic [5:0]  rom_id,
  input  logic [13:0] rom_addr,
  input  logic        rom_wr,
  input  logic [7:0]  rom_data,
  output logic        rom_wait,
  output logic [13:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_q,
  output logic [1:0]  bank_loaded,
  output logic        overflow
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  arb_state_e                          state_q;
  arb_state_e                          state_d;
  logic                                pop_c;
  logic                                accept_c;
  chargen_wr_t                         fifo_wdata;
  chargen_wr_t                         fifo_rdata;
  logic [CNT_W-1:0]                    fifo_count;
  logic                                fifo_full;
  logic                                fifo_empty;

  logic [CHAR_RAM_AW-1:0]              ram_addr_q;
  logic [CHAR_RAM_AW-1:0]              ram_addr_d;
  logic                                ram_we_q;
  logic                                ram_we_d;
  logic [CHAR_DW-1:0]                  ram_din_q;
  logic [CHAR_DW-1:0]                  ram_din_d;

  logic                                vid_d1_q;
  logic                                vid_d2_q;
  logic [CHAR_DW-1:0]                  dotD_q;
  logic                                dot_valid_q;
  logic                                overflow_q;
  logic [1:0]                          bank_loaded_q;
  logic [1:0][CHAR_BANK_AW-1:0]        wr_cnt_q;

  assign accept_c = rom_wr && !rom_addr[CHAR_BANK_AW] &&
                    ((rom_id == ROM_ID_W'(ID_BL)) || (rom_id == ROM_ID_W'(ID_BH)));

  assign fifo_wdata = '{bank: (rom_id == ROM_ID_W'(ID_BH)),
                        addr: rom_addr[CHAR_BANK_AW-1:0],
                        data: rom_data};

  chargen_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push_i  (accept_c),
    .wdata_i (fifo_wdata),
    .pop_i   (pop_c),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Loader backpressure straight from the occupancy register.
  assign rom_wait = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));

  // Arbiter state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next RAM port values; a video request this cycle blocks any write launch.
  always_comb begin
    state_d    = state_q;
    pop_c      = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_we_d   = 1'b0;
    ram_din_d  = ram_din_q;
    if (vid_req) begin
      ram_addr_d = {profile, dotA};
    end
    case (state_q)
      ARB_IDLE: begin
        if (!fifo_empty && !vid_req) begin
          state_d    = ARB_WRITE;
          pop_c      = 1'b1;
          ram_addr_d = {fifo_rdata.bank, fifo_rdata.addr};
          ram_we_d   = 1'b1;
          ram_din_d  = fifo_rdata.data;
        end
      end
      ARB_WRITE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Registered RAM port.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_din_q  <= '0;
    end else begin
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      ram_din_q  <= ram_din_d;
    end
  end

  // Video return pipeline: address out, RAM read, then capture into dotD.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vid_d1_q    <= 1'b0;
      vid_d2_q    <= 1'b0;
      dot_valid_q <= 1'b0;
      dotD_q      <= '0;
    end else begin
      vid_d1_q    <= vid_req;
      vid_d2_q    <= vid_d1_q;
      dot_valid_q <= vid_d2_q;
      if (vid_d2_q) begin
        dotD_q <= ram_q;
      end
    end
  end

  // Sticky drop flag and per-bank write counters that flag a bank once 8K writes land.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q    <= 1'b0;
      bank_loaded_q <= '0;
      wr_cnt_q      <= '0;
    end else begin
      if (accept_c && fifo_full) begin
        overflow_q <= 1'b1;
      end
      if (ram_we_q) begin
        wr_cnt_q[ram_addr_q[CHAR_BANK_AW]] <= wr_cnt_q[ram_addr_q[CHAR_BANK_AW]] + CHAR_BANK_AW'(1);
        if (wr_cnt_q[ram_addr_q[CHAR_BANK_AW]] == {CHAR_BANK_AW{1'b1}}) begin
          bank_loaded_q[ram_addr_q[CHAR_BANK_AW]] <= 1'b1;
        end
      end
    end
  end

  assign dotD        = dotD_q;
  assign dot_valid   = dot_valid_q;
  assign ram_addr    = ram_addr_q;
  assign ram_we      = ram_we_q;
  assign ram_din     = ram_din_q;
  assign bank_loaded = bank_loaded_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_chargen_arbiter.sv
// Directed plus randomized bench for chargen_arbiter against a queue-based reference.
module tb_chargen_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        profile = 1'b0;
  logic        vid_req = 1'b0;
  logic [12:0] dotA = '0;
  logic [7:0]  dotD;
  logic        dot_valid;
  logic [5:0]  rom_id = '0;
  logic [13:0] rom_addr = '0;
  logic        rom_wr = 1'b0;
  logic [7:0]  rom_data = '0;
  logic        rom_wait;
  logic [13:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_q;
  logic [1:0]  bank_loaded;
  logic        overflow;

  chargen_arbiter dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .profile     (profile),
    .vid_req     (vid_req),
    .dotA        (dotA),
    .dotD        (dotD),
    .dot_valid   (dot_valid),
    .rom_id      (rom_id),
    .rom_addr    (rom_addr),
    .rom_wr      (rom_wr),
    .rom_data    (rom_data),
    .rom_wait    (rom_wait),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_din     (ram_din),
    .ram_q       (ram_q),
    .bank_loaded (bank_loaded),
    .overflow    (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // Character RAM: synchronous read-before-write, data one cycle after address.
  logic [7:0] tb_mem [16384];
  always @(posedge clk_sys) begin
    ram_q <= tb_mem[ram_addr];
    if (ram_we) tb_mem[ram_addr] <= ram_din;
  end

  int          total = 0;
  int          bad   = 0;
  int          tick  = 0;
  int          nwr   = 0;
  int          wcnt [2];
  logic [21:0] wq [$];
  int          vdue [$];
  logic [7:0]  vval [$];
  logic [7:0]  last_dot = '0;
  logic        ov_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the negedge, update the reference, then check after the edge.
  task automatic cyc(input logic vid, input logic prof, input logic [12:0] da,
                     input logic wr, input logic [5:0] id, input logic [13:0] ad,
                     input logic [7:0] dt);
    logic        acc;
    logic [21:0] w;
    logic        we_seen;
    logic        we_bank;
    vid_req = vid; profile = prof; dotA = da;
    rom_wr = wr; rom_id = id; rom_addr = ad; rom_data = dt;
    acc = wr && (id == 6'd12 || id == 6'd13) && !ad[13];
    if (acc) begin
      if (wq.size() >= 4) ov_m = 1'b1;
      else wq.push_back({(id == 6'd13), ad[12:0], dt});
    end
    @(posedge clk_sys);
    @(negedge clk_sys);
    tick++;
    we_seen = ram_we;
    we_bank = ram_addr[13];
    if (we_seen) begin
      nwr++;
      if (wq.size() == 0) begin
        chk("unexpected_we", 32'(ram_we), 32'd0);
      end else begin
        w = wq.pop_front();
        chk("wr_addr_data", 32'({ram_addr, ram_din}), 32'(w));
      end
    end
    if (vid) begin
      chk("vid_addr", 32'(ram_addr), 32'({prof, da}));
      chk("vid_no_we", 32'(ram_we), 32'd0);
      vdue.push_back(tick + 2);
      vval.push_back(tb_mem[{prof, da}]);
    end
    if (vdue.size() != 0 && vdue[0] == tick) begin
      last_dot = vval[0];
      void'(vdue.pop_front());
      void'(vval.pop_front());
      chk("dot_valid_hi", 32'(dot_valid), 32'd1);
      chk("dotD_new", 32'(dotD), 32'(last_dot));
    end else begin
      chk("dot_valid_lo", 32'(dot_valid), 32'd0);
      chk("dotD_hold", 32'(dotD), 32'(last_dot));
    end
    chk("rom_wait", 32'(rom_wait), 32'(wq.size() >= 3));
    chk("overflow", 32'(overflow), 32'(ov_m));
    chk("bank_loaded", 32'(bank_loaded), 32'({wcnt[1] >= 8192, wcnt[0] >= 8192}));
    if (we_seen) wcnt[we_bank] = wcnt[we_bank] + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 13'd0, 1'b0, 6'd0, 14'd0, 8'd0);
  endtask

  task automatic chk_reset_outputs(input string ph);
    chk({ph, "_dotD"}, 32'(dotD), 32'd0);
    chk({ph, "_dot_valid"}, 32'(dot_valid), 32'd0);
    chk({ph, "_rom_wait"}, 32'(rom_wait), 32'd0);
    chk({ph, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({ph, "_ram_we"}, 32'(ram_we), 32'd0);
    chk({ph, "_ram_din"}, 32'(ram_din), 32'd0);
    chk({ph, "_bank_loaded"}, 32'(bank_loaded), 32'd0);
    chk({ph, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  // Asynchronous reset taken mid-cycle; reference state is cleared to match.
  task automatic do_reset(input int hold);
    #2;
    vid_req = 1'b0; rom_wr = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    repeat (hold) @(posedge clk_sys);
    @(negedge clk_sys);
    chk_reset_outputs("rst_hold");
    reset_n = 1'b1;
    wq.delete(); vdue.delete(); vval.delete();
    last_dot = '0; ov_m = 1'b0; wcnt[0] = 0; wcnt[1] = 0;
  endtask

  initial begin
    int          n0;
    int          sel;
    logic [5:0]  rid;
    logic [13:0] rad;
    wcnt[0] = 0; wcnt[1] = 0;

    do_reset(3);

    // Single download byte to bank BL.
    n0 = nwr;
    cyc(1'b0, 1'b0, 13'd0, 1'b1, 6'd12, 14'h0010, 8'hA5);
    idle(3);
    chk("dl_single_count", 32'(nwr - n0), 32'd1);

    // Seed bank BH then read it back through the video path.
    cyc(1'b0, 1'b0, 13'd0, 1'b1, 6'd13, 14'h0123, 8'h5A);
    idle(3);
    cyc(1'b1, 1'b1, 13'h0123, 1'b0, 6'd0, 14'd0, 8'd0);
    chk("vid_addr_2123", 32'(ram_addr), 32'h2123);
    idle(1);
    chk("vid_not_early", 32'(dot_valid), 32'd0);
    idle(1);
    chk("vid_dot_valid", 32'(dot_valid), 32'd1);
    chk("vid_dotD_5A", 32'(dotD), 32'h5A);
    idle(2);

    // Contention: three bytes queued under a 10-cycle video burst.
    n0 = nwr;
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 13'(i * 7), 1'b1, 6'd12, 14'(14'h0100 + i), 8'(8'hC0 + i));
    for (int i = 0; i < 7; i++)
      cyc(1'b1, 1'b1, 13'(i * 11), 1'b0, 6'd0, 14'd0, 8'd0);
    chk("burst_no_writes", 32'(nwr - n0), 32'd0);
    idle(8);
    chk("burst_drain_writes", 32'(nwr - n0), 32'd3);

    // Overflow: six bytes back-to-back while video holds the RAM.
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 1'b0, 13'd5, 1'b1, 6'd13, 14'(14'h0200 + i), 8'(8'h30 + i));
    chk("ovf_rom_wait", 32'(rom_wait), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    idle(10);
    chk("ovf_still_set", 32'(overflow), 32'd1);

    // Randomized mix of video fetches and downloads.
    for (int i = 0; i < 1500; i++) begin
      sel = int'($urandom_range(0, 3));
      rid = (sel == 0) ? 6'd12 : (sel == 1) ? 6'd13 : (sel == 2) ? 6'd5 : 6'($urandom_range(0, 63));
      rad = 14'($urandom_range(0, 8191));
      if ($urandom_range(0, 4) == 0) rad[13] = 1'b1;
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 13'($urandom_range(0, 8191)),
          1'($urandom_range(0, 9) < 4), rid, rad, 8'($urandom_range(0, 255)));
    end
    idle(12);

    // Reset with bytes queued and a fetch in flight.
    cyc(1'b1, 1'b0, 13'd1, 1'b1, 6'd12, 14'h0300, 8'h11);
    cyc(1'b1, 1'b0, 13'd2, 1'b1, 6'd13, 14'h0301, 8'h22);
    do_reset(2);
    n0 = nwr;
    idle(6);
    chk("post_reset_no_we", 32'(nwr - n0), 32'd0);

    // Load status: 8192 writes to BH, interleaved with ignored downloads.
    for (int i = 0; i < 8192; i++) begin
      cyc(1'b0, 1'b0, 13'd0, 1'b1, 6'd13, 14'(i & 8191), 8'($urandom_range(0, 255)));
      if (i[0]) cyc(1'b0, 1'b0, 13'd0, 1'b1, 6'd5, 14'(i & 8191), 8'hEE);
      else      cyc(1'b0, 1'b0, 13'd0, 1'b1, 6'd12, 14'(14'h2000 | (i & 8191)), 8'hDD);
    end
    idle(4);
    chk("load_write_count", 32'(nwr - n0), 32'd8192);
    chk("bank_loaded_bh", 32'(bank_loaded), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
